// File: rtl/decode_queue.sv
// RV32I pre-decode queue: words are decoded on enqueue and held in a DEPTH-entry
// circular buffer, drained by the dispatcher through a valid/ready handshake.
package decode_queue_pkg;

    typedef enum logic [5:0] {
        OP_NONE = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        is_load_or_store;
        logic        is_store;
        logic        is_branch;
        logic        illegal;
    } dec_t;

endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic                  in_pred_taken,
    output logic                  out_valid,
    input  logic                  out_ready,
    output op_t                   out_op,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [31:0]           out_imm,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic                  out_pred_taken,
    output logic                  out_is_load_or_store,
    output logic                  out_is_store,
    output logic                  out_is_branch,
    output logic                  out_illegal,
    output logic [$clog2(DEPTH):0] count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f, rs1_f, rs2_f;
    dec_t       dec;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rd_f   = in_inst[11:7];
    assign rs1_f  = in_inst[19:15];
    assign rs2_f  = in_inst[24:20];

    always_comb begin
        // NOTE: full default first so no path through the case can infer a latch.
        dec = '0;
        unique case (opcode)
            7'b0110111: begin
                dec.op  = OP_LUI;
                dec.rd  = rd_f;
                dec.imm = {in_inst[31:12], 12'b0};
            end
            7'b0010111: begin
                dec.op  = OP_AUIPC;
                dec.rd  = rd_f;
                dec.imm = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.op        = OP_JAL;
                dec.rd        = rd_f;
                dec.imm       = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                 in_inst[20], in_inst[30:21], 1'b0};
                dec.is_branch = 1'b1;
            end
            7'b1100111: begin
                if (funct3 == 3'b000) begin
                    dec.op        = OP_JALR;
                    dec.rd        = rd_f;
                    dec.rs1       = rs1_f;
                    dec.imm       = {{20{in_inst[31]}}, in_inst[31:20]};
                    dec.is_branch = 1'b1;
                end
            end
            7'b1100011: begin
                case (funct3)
                    3'b000:  dec.op = OP_BEQ;
                    3'b001:  dec.op = OP_BNE;
                    3'b100:  dec.op = OP_BLT;
                    3'b101:  dec.op = OP_BGE;
                    3'b110:  dec.op = OP_BLTU;
                    3'b111:  dec.op = OP_BGEU;
                    default: dec.op = OP_NONE;
                endcase
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.imm       = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                 in_inst[30:25], in_inst[11:8], 1'b0};
                dec.is_branch = 1'b1;
            end
            7'b0000011: begin
                case (funct3)
                    3'b000:  dec.op = OP_LB;
                    3'b001:  dec.op = OP_LH;
                    3'b010:  dec.op = OP_LW;
                    3'b100:  dec.op = OP_LBU;
                    3'b101:  dec.op = OP_LHU;
                    default: dec.op = OP_NONE;
                endcase
                dec.rd               = rd_f;
                dec.rs1              = rs1_f;
                dec.imm              = {{20{in_inst[31]}}, in_inst[31:20]};
                dec.is_load_or_store = 1'b1;
            end
            7'b0100011: begin
                case (funct3)
                    3'b000:  dec.op = OP_SB;
                    3'b001:  dec.op = OP_SH;
                    3'b010:  dec.op = OP_SW;
                    default: dec.op = OP_NONE;
                endcase
                dec.rs1              = rs1_f;
                dec.rs2              = rs2_f;
                dec.imm              = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                dec.is_load_or_store = 1'b1;
                dec.is_store         = 1'b1;
            end
            7'b0010011: begin
                dec.rd  = rd_f;
                dec.rs1 = rs1_f;
                dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
                case (funct3)
                    3'b000: dec.op = OP_ADDI;
                    3'b010: dec.op = OP_SLTI;
                    3'b011: dec.op = OP_SLTIU;
                    3'b100: dec.op = OP_XORI;
                    3'b110: dec.op = OP_ORI;
                    3'b111: dec.op = OP_ANDI;
                    3'b001: begin
                        dec.imm = {27'b0, in_inst[24:20]};
                        dec.op  = (funct7 == 7'b0000000) ? OP_SLLI : OP_NONE;
                    end
                    default: begin
                        dec.imm = {27'b0, in_inst[24:20]};
                        if (funct7 == 7'b0000000)      dec.op = OP_SRLI;
                        else if (funct7 == 7'b0100000) dec.op = OP_SRAI;
                        else                           dec.op = OP_NONE;
                    end
                endcase
            end
            7'b0110011: begin
                dec.rd  = rd_f;
                dec.rs1 = rs1_f;
                dec.rs2 = rs2_f;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec.op = OP_ADD;
                        3'b001:  dec.op = OP_SLL;
                        3'b010:  dec.op = OP_SLT;
                        3'b011:  dec.op = OP_SLTU;
                        3'b100:  dec.op = OP_XOR;
                        3'b101:  dec.op = OP_SRL;
                        3'b110:  dec.op = OP_OR;
                        default: dec.op = OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.op = OP_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.op = OP_SRA;
                end
            end
            default: dec.op = OP_NONE;
        endcase
        // Every rejected encoding collapses to the same all-zero illegal marker.
        if (dec.op == OP_NONE) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          full, empty, enq, deq;

    dec_t                entry_q [DEPTH];
    logic [PC_WIDTH-1:0] pc_q    [DEPTH];
    logic                pred_q  [DEPTH];

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = rdy_in && !full;
    assign out_valid = rdy_in && !empty;
    assign enq      = in_valid && in_ready && !flush_in;
    assign deq      = out_valid && out_ready && !flush_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) tail <= tail + 1'b1;
                if (deq) head <= head + 1'b1;
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: payload storage has no reset; outputs are masked by the empty check instead.
    always_ff @(posedge clk_in) begin
        if (enq) begin
            entry_q[tail] <= dec;
            pc_q[tail]    <= in_pc;
            pred_q[tail]  <= in_pred_taken;
        end
    end

    dec_t head_e;
    assign head_e = empty ? '0 : entry_q[head];

    assign out_op               = head_e.op;
    assign out_rd               = head_e.rd;
    assign out_rs1              = head_e.rs1;
    assign out_rs2              = head_e.rs2;
    assign out_imm              = head_e.imm;
    assign out_is_load_or_store = head_e.is_load_or_store;
    assign out_is_store         = head_e.is_store;
    assign out_is_branch        = head_e.is_branch;
    assign out_illegal          = head_e.illegal;
    assign out_pc               = empty ? '0 : pc_q[head];
    assign out_pred_taken       = empty ? 1'b0 : pred_q[head];
    assign count_out            = count;

endmodule
